// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: records fetch-time predictions in an in-order queue and
// resolves them in Execute. It produces a registered mispredict/redirect pulse
// and keeps resolution statistics.
module branch_resolve_unit #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [XLEN-1:0]          push_pc_i,
  input  logic                     push_taken_i,
  input  logic [XLEN-1:0]          push_target_i,
  input  logic                     exe_valid_i,
  input  logic [XLEN-1:0]          exe_pc_i,
  input  logic                     exe_taken_i,
  input  logic [XLEN-1:0]          exe_target_i,
  output logic                     mispredict_o,
  output logic [XLEN-1:0]          redirect_pc_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              resolved_cnt_o,
  output logic [31:0]              mispredict_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] tgt_mem [DEPTH];
  logic            tk_mem  [DEPTH];

  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   count_q;
  logic            mispredict_q;
  logic [XLEN-1:0] redirect_q;
  logic [31:0]     resolved_q, mispcnt_q;

  logic            empty, full, hit, pred_taken, misp, push_ok;
  logic [XLEN-1:0] pc_plus4, pred_tgt, redirect;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pc_plus4 = exe_pc_i + XLEN'(4);

  // Compare the head entry (or the not-taken default) against the actual outcome.
  always_comb begin
    hit        = exe_valid_i & ~empty & (pc_mem[rd_q] == exe_pc_i);
    pred_taken = hit ? tk_mem[rd_q]  : 1'b0;
    pred_tgt   = hit ? tgt_mem[rd_q] : pc_plus4;
    misp       = exe_valid_i &
                 ((pred_taken != exe_taken_i) |
                  (pred_taken & exe_taken_i & (pred_tgt != exe_target_i)));
    redirect   = exe_taken_i ? exe_target_i : pc_plus4;
    // Pushes during a detected or pending mispredict are wrong-path fetches.
    push_ok    = push_i & (~full | hit) & ~misp & ~mispredict_q;
  end

  // Prediction storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (!flush_i && !stall_i && push_ok) begin
      pc_mem[wr_q]  <= push_pc_i;
      tk_mem[wr_q]  <= push_taken_i;
      tgt_mem[wr_q] <= push_target_i;
    end
  end

  // Queue pointers, pulse output and statistics with rst > flush > stall priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      resolved_q   <= '0;
      mispcnt_q    <= '0;
    end else if (flush_i) begin
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
    end else if (!stall_i) begin
      mispredict_q <= misp;
      if (misp) redirect_q <= redirect;
      if (exe_valid_i) begin
        resolved_q <= resolved_q + 32'd1;
        mispcnt_q  <= mispcnt_q + 32'(misp);
      end
      if (misp) begin
        rd_q    <= '0;
        wr_q    <= '0;
        count_q <= '0;
      end else begin
        if (hit)     rd_q <= rd_q + AW'(1);
        if (push_ok) wr_q <= wr_q + AW'(1);
        count_q <= count_q + CW'(push_ok) - CW'(hit);
      end
    end
  end

  assign mispredict_o     = mispredict_q;
  assign redirect_pc_o    = redirect_q;
  assign full_o           = full;
  assign empty_o          = empty;
  assign count_o          = count_q;
  assign resolved_cnt_o   = resolved_q;
  assign mispredict_cnt_o = mispcnt_q;

endmodule
